// File: rtl/i2c_slave_byte_ctrl_pkg.sv
// Shared types and defaults for the I2C slave byte controller and its bus front end.
package i2c_slave_byte_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX       = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX       = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic [6:0] DEF_SLV_ADDR    = 7'h50;
  localparam int         DEF_SYNC_STAGES = 2;

  // General call (address 0) is never claimed.
  function automatic logic addr_hit(input logic [6:0] addr, input logic [6:0] own);
    return (addr == own) && (addr != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_slave_byte_ctrl_bus_sync.sv
// SCL/SDA synchronizers plus one delay stage; derives SCL edges and START/STOP conditions.
module i2c_slave_bus_sync
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic scl_async,
  input  logic sda_async,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_chain_reg;
  logic [SYNC_STAGES-1:0] sda_chain_reg;
  logic                   scl_dly_reg;
  logic                   sda_dly_reg;
  logic                   scl_sync;

  // No reset: the chain keeps tracking the live bus, so a reset can never fabricate an edge.
  always_ff @(posedge clk) begin
    scl_chain_reg <= {scl_chain_reg[SYNC_STAGES-2:0], scl_async};
    sda_chain_reg <= {sda_chain_reg[SYNC_STAGES-2:0], sda_async};
    scl_dly_reg   <= scl_sync;
    sda_dly_reg   <= sda_sync;
  end

  assign scl_sync = scl_chain_reg[SYNC_STAGES-1];
  assign sda_sync = sda_chain_reg[SYNC_STAGES-1];

  assign scl_rise = scl_sync & ~scl_dly_reg;
  assign scl_fall = ~scl_sync & scl_dly_reg;

  // SCL must be high on both samples, so an SDA edge coincident with an SCL edge stays data.
  assign start_det = scl_sync & scl_dly_reg & sda_dly_reg & ~sda_sync;
  assign stop_det  = scl_sync & scl_dly_reg & ~sda_dly_reg & sda_sync;

endmodule

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave: address match, byte receive/transmit, open-drain SDA via output enable.
module i2c_slave_byte_ctrl
  import i2c_slave_byte_ctrl_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = DEF_SLV_ADDR,
  parameter int         SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oe,
  input  logic       Ack_en,
  input  logic [7:0] Tx_data,
  output logic       Tx_load,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  output logic       Addr_match,
  output logic       Rw,
  output logic       Master_nack,
  output logic       Stop_det,
  output logic       Busy
);

  logic sda_sync, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk       (Clk),
    .scl_async (Scl_i),
    .sda_async (Sda_i),
    .sda_sync  (sda_sync),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [6:0] tx_bits_reg, tx_bits_next;
  logic       byte_done_reg, byte_done_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       rw_reg, rw_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       busy_reg, busy_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       addr_match_reg, addr_match_next;
  logic       tx_load_reg, tx_load_next;
  logic       master_nack_reg, master_nack_next;
  logic       stop_det_reg, stop_det_next;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_reg[6:0], sda_sync};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg       <= ST_IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      tx_bits_reg     <= '0;
      byte_done_reg   <= 1'b0;
      sda_oe_reg      <= 1'b0;
      rw_reg          <= 1'b0;
      rx_data_reg     <= '0;
      busy_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      addr_match_reg  <= 1'b0;
      tx_load_reg     <= 1'b0;
      master_nack_reg <= 1'b0;
      stop_det_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      tx_bits_reg     <= tx_bits_next;
      byte_done_reg   <= byte_done_next;
      sda_oe_reg      <= sda_oe_next;
      rw_reg          <= rw_next;
      rx_data_reg     <= rx_data_next;
      busy_reg        <= busy_next;
      rx_valid_reg    <= rx_valid_next;
      addr_match_reg  <= addr_match_next;
      tx_load_reg     <= tx_load_next;
      master_nack_reg <= master_nack_next;
      stop_det_reg    <= stop_det_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    tx_bits_next     = tx_bits_reg;
    byte_done_next   = byte_done_reg;
    sda_oe_next      = sda_oe_reg;
    rw_next          = rw_reg;
    rx_data_next     = rx_data_reg;
    busy_next        = busy_reg;
    rx_valid_next    = 1'b0;
    addr_match_next  = 1'b0;
    tx_load_next     = 1'b0;
    master_nack_next = 1'b0;
    stop_det_next    = 1'b0;

    if (start_det) begin
      state_next     = ST_ADDR;
      bit_cnt_next   = '0;
      byte_done_next = 1'b0;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b1;
    end else if (stop_det) begin
      state_next     = ST_IDLE;
      byte_done_next = 1'b0;
      sda_oe_next    = 1'b0;
      busy_next      = 1'b0;
      stop_det_next  = 1'b1;
    end else begin
      case (state_reg)
        ST_ADDR, ST_RX: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              byte_done_next = 1'b1;
              if (state_reg == ST_ADDR) begin
                rw_next         = sda_sync;
                addr_match_next = addr_hit(rx_byte[7:1], SLV_ADDR);
              end else begin
                rx_data_next  = rx_byte;
                rx_valid_next = 1'b1;
              end
            end
          end else if (scl_fall && byte_done_reg) begin
            // byte_done separates the fall ending bit 8 from the fall right after START.
            byte_done_next = 1'b0;
            if (state_reg == ST_ADDR) begin
              if (addr_hit(shift_reg[7:1], SLV_ADDR)) begin
                sda_oe_next = 1'b1;
                state_next  = ST_ADDR_ACK;
              end else begin
                state_next  = ST_IGNORE;
              end
            end else begin
              sda_oe_next = Ack_en;
              state_next  = ST_RX_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_next = '0;
            if (rw_reg) begin
              tx_bits_next = Tx_data[6:0];
              tx_load_next = 1'b1;
              sda_oe_next  = ~Tx_data[7];
              state_next   = ST_TX;
            end else begin
              sda_oe_next  = 1'b0;
              state_next   = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_next  = 1'b0;
            bit_cnt_next = '0;
            state_next   = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd7) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              state_next   = ST_TX_ACK;
            end else begin
              sda_oe_next  = ~tx_bits_reg[6];
              tx_bits_next = {tx_bits_reg[5:0], 1'b0};
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          // A NACK leaves on the rise, so any fall still seen here ends an ACKed byte.
          if (scl_rise && sda_sync) begin
            master_nack_next = 1'b1;
            state_next       = ST_IGNORE;
          end else if (scl_fall) begin
            tx_bits_next = Tx_data[6:0];
            tx_load_next = 1'b1;
            sda_oe_next  = ~Tx_data[7];
            bit_cnt_next = '0;
            state_next   = ST_TX;
          end
        end
        ST_IGNORE: begin
          sda_oe_next = 1'b0;
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  assign Sda_oe      = sda_oe_reg;
  assign Tx_load     = tx_load_reg;
  assign Rx_data     = rx_data_reg;
  assign Rx_valid    = rx_valid_reg;
  assign Addr_match  = addr_match_reg;
  assign Rw          = rw_reg;
  assign Master_nack = master_nack_reg;
  assign Stop_det    = stop_det_reg;
  assign Busy        = busy_reg;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: behavioural I2C master with a transaction-level expectation model.
module tb_i2c_slave_byte_ctrl;

  localparam logic [6:0] OWN = 7'h50;
  localparam int Q = 8;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       Ack_en = 1'b0;
  logic [7:0] Tx_data = 8'h00;
  logic       Sda_oe, Tx_load, Rx_valid, Addr_match, Rw, Master_nack, Stop_det, Busy;
  logic [7:0] Rx_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~Sda_oe;

  always #5 Clk = ~Clk;

  i2c_slave_byte_ctrl #(.SLV_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Scl_i       (scl_m),
    .Sda_i       (sda_bus),
    .Sda_oe      (Sda_oe),
    .Ack_en      (Ack_en),
    .Tx_data     (Tx_data),
    .Tx_load     (Tx_load),
    .Rx_data     (Rx_data),
    .Rx_valid    (Rx_valid),
    .Addr_match  (Addr_match),
    .Rw          (Rw),
    .Master_nack (Master_nack),
    .Stop_det    (Stop_det),
    .Busy        (Busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_am = 0, n_rv = 0, n_tl = 0, n_nk = 0, n_sd = 0, n_oe = 0, n_wide = 0;
  int e_am = 0, e_rv = 0, e_tl = 0, e_nk = 0, e_sd = 0;
  logic [4:0] prev_p = 5'd0;
  logic [7:0] dat [4];

  // Pulse counters and a pulse-width watch, sampled away from the active edge.
  always @(negedge Clk) begin
    if (Addr_match)  n_am++;
    if (Rx_valid)    n_rv++;
    if (Tx_load)     n_tl++;
    if (Master_nack) n_nk++;
    if (Stop_det)    n_sd++;
    if (Sda_oe)      n_oe++;
    if (|({Addr_match, Rx_valid, Tx_load, Master_nack, Stop_det} & prev_p)) n_wide++;
    prev_p = {Addr_match, Rx_valid, Tx_load, Master_nack, Stop_det};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int k);
    repeat (k * Q) @(negedge Clk);
  endtask

  task automatic clk_bit(input logic b, output logic seen);
    sda_m = b;
    wait_q(1);
    scl_m = 1'b1;
    wait_q(1);
    seen = sda_bus;
    wait_q(1);
    scl_m = 1'b0;
    wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] seen);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(d[i], s);
      seen[i] = s;
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q(1);
    scl_m = 1'b1;
    wait_q(1);
    sda_m = 1'b0;
    wait_q(1);
    scl_m = 1'b0;
    wait_q(1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q(1);
    scl_m = 1'b1;
    wait_q(1);
    sda_m = 1'b1;
    wait_q(2);
  endtask

  // One complete transfer; expectations follow from address, direction and Ack_en alone.
  task automatic xact(input logic [6:0] a, input logic rw, input int n, input logic aen,
                      input logic do_stop);
    logic       match, s;
    logic [7:0] seen;
    int         oe0;
    match = (a == OWN) && (a != 7'd0);
    oe0 = n_oe;
    Ack_en = aen;
    if (rw) Tx_data = dat[0];
    $display("xact addr=%02h rw=%0d bytes=%0d ack_en=%0d claimed=%0d stop=%0d",
             a, rw, n, aen, match, do_stop);
    i2c_start();
    check("busy_after_start", 32'(Busy), 32'd1);
    send_byte({a, rw}, seen);
    clk_bit(1'b1, s);
    check("addr_ack_bit", 32'(s), 32'(!match));
    check("rw", 32'(Rw), 32'(rw));
    if (match) e_am++;
    check("addr_match_cnt", 32'(n_am), 32'(e_am));
    if (match && rw) e_tl++;
    check("tx_load_at_ack_fall", 32'(n_tl), 32'(e_tl));
    for (int i = 0; i < n; i++) begin
      if (!rw) begin
        send_byte(dat[i], seen);
        clk_bit(1'b1, s);
        check("data_ack_bit", 32'(s), 32'(!(match && aen)));
        if (match) begin
          e_rv++;
          check("rx_data", 32'(Rx_data), 32'(dat[i]));
        end
        check("rx_valid_cnt", 32'(n_rv), 32'(e_rv));
      end else begin
        send_byte(8'hFF, seen);
        check("tx_byte", 32'(seen), match ? 32'(dat[i]) : 32'h0FF);
        if (i + 1 < n) Tx_data = dat[i + 1];
        clk_bit((i == n - 1), s);
        if (match && (i + 1 < n)) e_tl++;
        check("tx_load_cnt", 32'(n_tl), 32'(e_tl));
      end
    end
    if (match && rw) begin
      e_nk++;
      check("master_nack_cnt", 32'(n_nk), 32'(e_nk));
      check("oe_after_nack", 32'(Sda_oe), 32'd0);
    end
    if (!match) check("oe_quiet", 32'(n_oe), 32'(oe0));
    if (do_stop) begin
      i2c_stop();
      e_sd++;
      check("stop_det_cnt", 32'(n_sd), 32'(e_sd));
      check("busy_after_stop", 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    logic [6:0] a;
    logic       rw, aen, stp, s;
    logic [4:0] tail;
    logic [7:0] seen;
    int         n, sel;

    repeat (6) @(negedge Clk);
    check("reset_outputs", 32'({Sda_oe, Tx_load, Rx_data, Rx_valid, Addr_match, Rw,
                                Master_nack, Stop_det, Busy}), 32'd0);
    Rst = 1'b0;
    wait_q(2);
    check("idle_outputs", 32'({Sda_oe, Busy, Rw}), 32'd0);

    // Write 0x3C to own address.
    dat[0] = 8'h3C;
    xact(OWN, 1'b0, 1, 1'b1, 1'b1);
    // Foreign address 0x51 with two bytes.
    dat[0] = 8'($urandom);
    dat[1] = 8'($urandom);
    xact(7'h51, 1'b0, 2, 1'b1, 1'b1);
    // Read 0x96 then 0x5A, ACK then NACK.
    dat[0] = 8'h96;
    dat[1] = 8'h5A;
    xact(OWN, 1'b1, 2, 1'b1, 1'b1);
    // Write 0x11, repeated START, read.
    dat[0] = 8'h11;
    xact(OWN, 1'b0, 1, 1'b1, 1'b0);
    dat[0] = 8'($urandom);
    xact(OWN, 1'b1, 1, 1'b1, 1'b1);
    // Data NACK via Ack_en=0; second byte still received.
    dat[0] = 8'hFF;
    dat[1] = 8'($urandom);
    xact(OWN, 1'b0, 2, 1'b0, 1'b1);
    // General call is not claimed.
    dat[0] = 8'($urandom);
    xact(7'h00, 1'b0, 1, 1'b1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      sel = int'($urandom_range(0, 3));
      if (sel < 2) a = OWN;
      else if (sel == 2) a = 7'($urandom_range(0, 127));
      else a = 7'd0;
      rw  = 1'($urandom_range(0, 1));
      aen = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      stp = (t == 7) || ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) dat[k] = 8'($urandom);
      xact(a, rw, n, aen, stp);
    end

    // Reset in the middle of a read while the slave is pulling SDA low.
    $display("xact reset-mid-read addr=%02h", OWN);
    Ack_en = 1'b1;
    Tx_data = 8'h00;
    i2c_start();
    send_byte({OWN, 1'b1}, seen);
    clk_bit(1'b1, s);
    check("rst_read_addr_ack", 32'(s), 32'd0);
    e_am++;
    e_tl++;
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    check("oe_before_reset", 32'(Sda_oe), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    check("outputs_after_reset", 32'({Sda_oe, Tx_load, Rx_data, Rx_valid, Addr_match, Rw,
                                      Master_nack, Stop_det, Busy}), 32'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    sel = n_oe;
    for (int i = 4; i >= 0; i--) begin
      clk_bit(1'b1, s);
      tail[i] = s;
    end
    clk_bit(1'b0, s);
    check("ignored_tail_bits", 32'(tail), 32'h1F);
    check("ignored_oe_quiet", 32'(n_oe), 32'(sel));
    check("ignored_tx_load", 32'(n_tl), 32'(e_tl));
    dat[0] = 8'($urandom);
    xact(OWN, 1'b0, 1, 1'b1, 1'b1);

    check("pulse_width", 32'(n_wide), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_byte_ctrl.md
Name: i2c_slave_byte_ctrl

Overview:
- Byte-level I2C slave (responder). It is the far-bus counterpart of the team's I2C master byte/bit controllers.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Receives and matches the 7-bit address, ACKs it, then receives bytes (master write) or transmits bytes (master read).
- Byte-wide handshake to the user register file; drives SDA open-drain through an output-enable. No clock stretching.

Parameters:
- SLV_ADDR, 7'h50, own 7-bit bus address.
- SYNC_STAGES, 2, synchronizer flops on Scl_i/Sda_i (minimum 2).

Ports:
- Clk  in  1  system clock; must be at least 10x the SCL rate.
- Rst  in  1  synchronous, active-high reset.
- Scl_i  in  1  bus SCL (asynchronous).
- Sda_i  in  1  bus SDA (asynchronous).
- Sda_oe  out  1  1 = pull SDA low; 0 = release.
- Ack_en  in  1  1 = ACK received data bytes; 0 = NACK them.
- Tx_data  in  8  byte to send on a master read; sampled when Tx_load=1.
- Tx_load  out  1  1-cycle pulse: Tx_data captured into the shift register.
- Rx_data  out  8  last received data byte.
- Rx_valid  out  1  1-cycle pulse: Rx_data updated.
- Addr_match  out  1  1-cycle pulse: address matched.
- Rw  out  1  R/W bit of the current transfer (1 = master read).
- Master_nack  out  1  1-cycle pulse: master NACKed a transmitted byte.
- Stop_det  out  1  1-cycle pulse: STOP seen.
- Busy  out  1  high from START until STOP.

Behaviour:
- Reset state: every output is 0, state=IDLE, shift register and bit counter are cleared.
- Reset mid-transfer: the bus is ignored until the next START.
- Synchronization: signals pass through SYNC_STAGES flops plus one delay register.
  - scl_rise/scl_fall are the edges of the synced SCL.
- START = synced SDA falls while synced SCL is high on both the current and previous sample.
- STOP = synced SDA rises under the same SCL condition.
- If an SDA edge coincides with an SCL edge in the same cycle, it is treated as data, not as START/STOP.
- START in any state, including repeated START:
  - state=ADDR, bit count=0, Sda_oe=0, Busy=1.
  - Takes priority over all other transitions.
- STOP in any state: state=IDLE, Sda_oe=0, Busy=0, Stop_det pulses.
- Data is sampled on scl_rise, MSB first. Sda_oe changes only on scl_fall.
- States and transitions:
  - IDLE: leaves only on START.
  - ADDR: shifts 8 bits.
    - At the 8th scl_rise: Rw <= bit0; if bits[7:1]==SLV_ADDR, Addr_match pulses in that same cycle.
    - On the next scl_fall: on a match, Sda_oe=1 and go to ADDR_ACK; otherwise go to IGNORE.
  - ADDR_ACK: on scl_fall (end of the ACK bit):
    - Rw=0: Sda_oe=0, go to RX.
    - Rw=1: Tx_data is loaded, Tx_load pulses, Sda_oe=~Tx_data[7], go to TX.
  - RX: shifts 8 bits.
    - At the 8th scl_rise: Rx_data updated and Rx_valid pulses in the same cycle.
    - On the next scl_fall: Sda_oe=Ack_en, go to RX_ACK.
  - RX_ACK: on scl_fall, Sda_oe=0, bit count=0, go to RX.
    - The bus NACK does not change state; the master ends with STOP or repeated START.
  - TX: on each scl_fall, shift and drive Sda_oe=~next bit.
    - On the scl_fall after bit 0: Sda_oe=0, go to TX_ACK.
  - TX_ACK: the master's bit is sampled on scl_rise.
    - 0 (ACK): on the next scl_fall, reload Tx_data, pulse Tx_load, drive bit7, go to TX.
    - 1 (NACK): Master_nack pulses at that scl_rise, go to IGNORE.
  - IGNORE: Sda_oe=0; waits for START or STOP.
- Counters and latency:
  - Bit counter is 3 bits and wraps 7->0 at the byte boundary; a 9th-bit counter is not used.
  - Pulse outputs are exactly 1 Clk wide and registered.
  - Edge-to-output latency is SYNC_STAGES+1 Clk.
- General call (address 0) is not supported and is treated as a mismatch.

Decomposition:
- Shared defines file i2c_slave_defines.v holds the state encodings (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE; 3-bit) and SLV_ADDR default. It is included alongside i2c_master_defines.v.
- Sub-module i2c_slave_bus_sync contains the synchronizers, delay registers and scl_rise/scl_fall/start_det/stop_det generation. It is reused by the bench monitor.

Test Plan:
- Write 0xA0 (addr 0x50 W), data 0x3C, Ack_en=1, then STOP -> Addr_match pulse; SDA low at both 9th clocks; Rx_data=0x3C with one Rx_valid pulse; Stop_det pulse; Busy 0.
- Addr 0x51 (write 0xA2), then 2 bytes -> no Addr_match; Sda_oe stays 0 for the whole transfer; Rx_valid never pulses.
- Read 0xA1, Tx_data=0x96 then 0x5A, master ACK then NACK, then STOP -> SDA carries 1001_0110 then 0101_1010; Tx_load pulses twice; Master_nack pulses once; Sda_oe=0 after the NACK.
- Write 0xA0 + 0x11, repeated START, read 0xA1 -> Rw goes 0 then 1; second Addr_match pulse; Tx_load at the ACK-bit fall.
- Ack_en=0 during a write of 0xFF -> SDA released at the 9th clock; Rx_data=0xFF; next byte is still received.
- Rst asserted mid-byte during a read -> Sda_oe=0 next cycle and all outputs 0; the block ignores traffic until a fresh START, then a correct address ACK.
